// File: rtl/mem_port_sched_pkg.sv
// Shared types and helpers for the round-robin memory port scheduler.
package mem_port_sched_pkg;

  // Scheduler FSM: arbitrate in IDLE, own the port for a whole burst in BURST.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Index reached by stepping `step` places past `base`, wrapping at `ports`.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned ports);
    return (base + step) % ports;
  endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester-side and memory-side signal bundle of the scheduler.
// slave  : the scheduler itself.
// master : the environment (requesters plus memory).
interface mem_port_sched_if #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [PORTS-1:0]            req_we;
  logic [PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [PORTS*LEN_WIDTH-1:0]  req_len;
  logic                        mem_valid;
  logic                        mem_ready;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic                        mem_we;
  logic [DATA_WIDTH-1:0]       mem_wdata;
  logic                        mem_rsp_valid;
  logic [DATA_WIDTH-1:0]       mem_rsp_data;
  logic [PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic [$clog2(PORTS)-1:0]    grant_encoded;
  logic                        busy;
  logic                        err_rsp;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_len,
    input  mem_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wdata,
    output rsp_valid, rsp_data, grant_encoded, busy, err_rsp
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_len,
    output mem_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata,
    input  rsp_valid, rsp_data, grant_encoded, busy, err_rsp
  );
endinterface

// File: rtl/mem_port_sched_id_fifo.sv
// Small synchronous FIFO holding the issuing port ID of each outstanding read.
// Pushes while full and pops while empty are ignored.
module mem_port_sched_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointer increment that wraps at DEPTH (DEPTH need not fill the pointer range).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards every outstanding ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mem_port_sched.sv
// Round-robin burst scheduler sharing one memory command port between PORTS
// requesters; in-order read responses are routed back via a port-ID FIFO.
module mem_port_sched #(
  parameter int PORTS       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_sched_if.slave   bus
);
  import mem_port_sched_pkg::*;

  localparam int GW = $clog2(PORTS);
  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam logic [PORTS-1:0] RSP_ONE = {{(PORTS-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, prio_q, prio_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PORTS-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  logic [GW-1:0]         win_idx, cand;
  logic                  win_found, win_hit;
  logic                  in_burst, blk, xfer, mem_valid_c;
  logic [PORTS-1:0]      req_ready_c;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [GW-1:0]         fifo_head;
  logic [CW-1:0]         fifo_count;

  mem_port_sched_id_fifo #(.WIDTH(GW), .DEPTH(OUTSTANDING)) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (grant_q),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Round-robin search: first requesting port at or after prio_q, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    win_hit   = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      cand      = GW'(rr_index(32'(prio_q), i, PORTS));
      win_hit   = !win_found && bus.req_valid[cand];
      win_idx   = win_hit ? cand : win_idx;
      win_found = win_found | win_hit;
    end
  end

  // Command path of the granted port; reads stall on a full ID FIFO (registered count only).
  always_comb begin
    in_burst              = (state_q == ST_BURST);
    blk                   = !bus.req_we[grant_q] && fifo_full;
    mem_valid_c           = in_burst && bus.req_valid[grant_q] && !blk;
    req_ready_c           = '0;
    req_ready_c[grant_q]  = in_burst && bus.mem_ready && !blk;
    xfer                  = mem_valid_c && bus.mem_ready;
    fifo_push             = xfer && !bus.req_we[grant_q];
    fifo_pop              = bus.mem_rsp_valid && !fifo_empty;
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.mem_valid     = mem_valid_c;
  assign bus.mem_addr      = bus.req_addr[32'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_we        = bus.req_we[grant_q];
  assign bus.mem_wdata     = bus.req_wdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_encoded = grant_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.err_rsp       = err_q;
  assign bus.busy          = (state_q == ST_BURST) || (fifo_count != {CW{1'b0}});

  // Next-state: arbitration, beat counting, response routing and error flag.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d    = win_idx;
          beat_cnt_d = bus.req_len[32'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
          state_d    = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (xfer && (beat_cnt_q == {LEN_WIDTH{1'b0}})) begin
          prio_d  = GW'(rr_index(32'(grant_q), 32'd1, PORTS));
          state_d = ST_IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
        end else begin
          state_d = ST_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_valid_d = fifo_pop ? (RSP_ONE << fifo_head) : {PORTS{1'b0}};
    rsp_data_d  = bus.mem_rsp_valid ? bus.mem_rsp_data : rsp_data_q;
    err_d       = err_q | (bus.mem_rsp_valid & fifo_empty);
  end

  // Scheduler state and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      prio_q      <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: per-cycle vector tables plus a few
// hand-written sequences. Inputs change on the falling edge; outputs are
// checked 1 ns later, i.e. they describe the cycle ending at the next rise.
`timescale 1ns/1ps
module tb_mem_port_sched;
  localparam int PORTS = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int OST   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_sched_if #(.PORTS(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_port_sched #(
    .PORTS(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUTSTANDING(OST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] we;
    logic       mr;
    logic       rspv;
    logic [3:0] e_ready;
    logic       e_mv;
    logic [1:0] e_grant;
    logic       e_busy;
    logic [3:0] e_rsp;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] paddr(input int i);
    return 32'h0000_1000 * 32'(i + 1);
  endfunction

  task automatic set_port(input int i, input logic [31:0] a, input logic [3:0] len);
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    bus.req_len[i*LW +: LW]   = len;
  endtask

  task automatic add(input logic [3:0] rv, input logic [3:0] we, input logic mr, input logic rspv,
                     input logic [3:0] e_ready, input logic e_mv, input logic [1:0] e_grant,
                     input logic e_busy, input logic [3:0] e_rsp, input logic e_err);
    vec_t v;
    v.rv = rv; v.we = we; v.mr = mr; v.rspv = rspv;
    v.e_ready = e_ready; v.e_mv = e_mv; v.e_grant = e_grant;
    v.e_busy = e_busy; v.e_rsp = e_rsp; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[k]) begin
      @(negedge clk);
      bus.req_valid     = vecs[k].rv;
      bus.req_we        = vecs[k].we;
      bus.mem_ready     = vecs[k].mr;
      bus.mem_rsp_valid = vecs[k].rspv;
      bus.mem_rsp_data  = 32'hC0DE_0000 + 32'(k);
      #1;
      chk($sformatf("%s[%0d].req_ready", tag, k), 64'(bus.req_ready), 64'(vecs[k].e_ready));
      chk($sformatf("%s[%0d].mem_valid", tag, k), 64'(bus.mem_valid), 64'(vecs[k].e_mv));
      chk($sformatf("%s[%0d].grant", tag, k), 64'(bus.grant_encoded), 64'(vecs[k].e_grant));
      chk($sformatf("%s[%0d].busy", tag, k), 64'(bus.busy), 64'(vecs[k].e_busy));
      chk($sformatf("%s[%0d].rsp_valid", tag, k), 64'(bus.rsp_valid), 64'(vecs[k].e_rsp));
      chk($sformatf("%s[%0d].err_rsp", tag, k), 64'(bus.err_rsp), 64'(vecs[k].e_err));
      if (vecs[k].e_mv) begin
        chk($sformatf("%s[%0d].mem_addr", tag, k), 64'(bus.mem_addr), 64'(paddr(int'(vecs[k].e_grant))));
      end
    end
    vecs.delete();
  endtask

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_we        = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, ".mem_valid"}, 64'(bus.mem_valid), 64'd0);
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".rsp_data"},  64'(bus.rsp_data),  64'd0);
    chk({tag, ".grant"},     64'(bus.grant_encoded), 64'd0);
    chk({tag, ".busy"},      64'(bus.busy),      64'd0);
    chk({tag, ".err_rsp"},   64'(bus.err_rsp),   64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    for (int i = 0; i < PORTS; i++) set_port(i, paddr(i), 4'd0);
    do_reset();

    // Single read burst: port 0, len 3, address stepping per beat.
    set_port(0, 32'h0000_0100, 4'd3);
    @(negedge clk);
    bus.req_valid = 4'b0001; bus.req_we = 4'b0000; bus.mem_ready = 1'b1;
    #1;
    chk("rd.arb_cycle.mem_valid", 64'(bus.mem_valid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.req_addr[0 +: AW] = 32'h0000_0100 + 32'(b * 4);
      #1;
      chk($sformatf("rd.beat%0d.grant", b), 64'(bus.grant_encoded), 64'd0);
      chk($sformatf("rd.beat%0d.mem_valid", b), 64'(bus.mem_valid), 64'd1);
      chk($sformatf("rd.beat%0d.req_ready", b), 64'(bus.req_ready), 64'h1);
      chk($sformatf("rd.beat%0d.mem_addr", b), 64'(bus.mem_addr), 64'(32'h0000_0100 + 32'(b * 4)));
      chk($sformatf("rd.beat%0d.mem_we", b), 64'(bus.mem_we), 64'd0);
    end
    @(negedge clk);
    bus.req_valid = 4'b0000; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hD000_0000;
    #1;
    chk("rd.after.mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rd.after.busy", 64'(bus.busy), 64'd1);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      bus.mem_rsp_valid = (b < 4);
      bus.mem_rsp_data  = 32'hD000_0000 + 32'(b);
      #1;
      chk($sformatf("rd.rsp%0d.rsp_valid", b), 64'(bus.rsp_valid), 64'h1);
      chk($sformatf("rd.rsp%0d.rsp_data", b), 64'(bus.rsp_data), 64'(32'hD000_0000 + 32'(b - 1)));
    end
    @(negedge clk);
    #1;
    chk("rd.drained.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rd.drained.busy", 64'(bus.busy), 64'd0);
    chk("rd.drained.err_rsp", 64'(bus.err_rsp), 64'd0);

    // Round-robin: four single-beat writes held on all ports.
    do_reset();
    for (int i = 0; i < PORTS; i++) set_port(i, paddr(i), 4'd0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0);
    add(4'hF, 4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'h0, 1'b0);
    run_vecs("rr");

    // Stall mid-burst and a dropped valid: port 3, three write beats.
    do_reset();
    set_port(3, paddr(3), 4'd2);
    add(4'h8, 4'h8, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h0, 4'h8, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h8, 4'h8, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 4'h0, 1'b0);
    add(4'h0, 4'h8, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0);
    // Unexpected response with nothing outstanding: sticky error, no routing.
    add(4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0);
    add(4'h0, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'h0, 1'b1);
    add(4'h0, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'h0, 1'b1);
    run_vecs("stall");

    // FIFO full: port 1 reads eight beats, responses held back until one is returned.
    do_reset();
    set_port(1, paddr(1), 4'd7);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 4'h0, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h2, 1'b0);
    add(4'h2, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'h0, 1'b0);
    run_vecs("full");

    // Reset mid-burst: port 2 reads, reset asserted during beat 2 between edges.
    do_reset();
    set_port(2, paddr(2), 4'd3);
    @(negedge clk);
    bus.req_valid = 4'b0100; bus.req_we = 4'b0000; bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid.beat1.req_ready", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    #1;
    chk("rstmid.beat2.req_ready", 64'(bus.req_ready), 64'h4);
    chk("rstmid.beat2.grant", 64'(bus.grant_encoded), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("rstmid.async");
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0000; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h5555_AAAA;
    #1;
    chk("rstmid.release.err_rsp", 64'(bus.err_rsp), 64'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0; bus.req_valid = 4'b1100;
    #1;
    chk("rstmid.late_rsp.err_rsp", 64'(bus.err_rsp), 64'd1);
    chk("rstmid.late_rsp.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rstmid.arb.mem_valid", 64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rstmid.regrant.grant", 64'(bus.grant_encoded), 64'd2);
    chk("rstmid.regrant.req_ready", 64'(bus.req_ready), 64'h4);
    chk("rstmid.regrant.mem_addr", 64'(bus.mem_addr), 64'(paddr(2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Round-robin burst scheduler that shares one memory command port between `PORTS` requesters. It sits between the requester-side bus masters and the single memory/interconnect port. Each winner keeps the port for a whole burst of `len+1` beats. In-order read responses are routed back to the issuing requester through an internal port-ID FIFO.

## Interface
Parameters:
- `PORTS`, 4, number of requesters (2..16).
- `ADDR_WIDTH`, 32, beat address width.
- `DATA_WIDTH`, 32, write/read data width.
- `LEN_WIDTH`, 4, burst length field width; burst = `len+1` beats (1..16).
- `OUTSTANDING`, 4, max read beats issued but not yet answered; also the ID FIFO depth (power of 2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  PORTS  per-port beat valid; the first beat also requests arbitration.
- `req_ready`  out  PORTS  per-port beat accept; only the granted bit can be 1.
- `req_addr`  in  PORTS*ADDR_WIDTH  flat; port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_we`  in  PORTS  1 = write beat, 0 = read beat.
- `req_wdata`  in  PORTS*DATA_WIDTH  flat write data.
- `req_len`  in  PORTS*LEN_WIDTH  beats-1; sampled only at grant.
- `mem_valid`  out  1  command beat valid toward memory.
- `mem_ready`  in  1  memory accepts the beat.
- `mem_addr`  out  ADDR_WIDTH  muxed from the granted port.
- `mem_we`  out  1  muxed from the granted port.
- `mem_wdata`  out  DATA_WIDTH  muxed from the granted port.
- `mem_rsp_valid`  in  1  read data return, in issue order, no backpressure.
- `mem_rsp_data`  in  DATA_WIDTH  read data.
- `rsp_valid`  out  PORTS  one-hot: the response belongs to port i.
- `rsp_data`  out  DATA_WIDTH  registered copy of `mem_rsp_data`, broadcast to all ports.
- `grant_encoded`  out  $clog2(PORTS)  current/last granted port.
- `busy`  out  1  state is BURST, or the ID FIFO is non-empty.
- `err_rsp`  out  1  sticky flag: a response arrived with the ID FIFO empty.

## Operation
States are IDLE and BURST.

**IDLE**
- If any `req_valid` is set, pick the first set bit searching from `prio_ptr` upward, wrapping modulo PORTS.
- On the next edge: register the winner into `grant_encoded`, load `beat_cnt` from that port's `req_len`, go to BURST.
- If no `req_valid` is set, stay in IDLE.

**BURST**
- `mem_valid = req_valid[g] && !blk`, where `blk` = (`req_we[g]==0` && FIFO full).
- `req_ready[g] = mem_ready && !blk`.
- All mem_* command outputs are combinational muxes of port g.
- A beat transfers when `req_valid[g] && req_ready[g]`.
- Each read beat pushes `g` into the ID FIFO. Write beats push nothing.
- On a transfer with `beat_cnt != 0`: decrement `beat_cnt`.
- On a transfer with `beat_cnt == 0` (last beat): set `prio_ptr = (g+1) mod PORTS` and go to IDLE.
- A requester that drops `req_valid` mid-burst does not lose the grant. The burst completes only after `len+1` transfers.

**Responses**
- On `mem_rsp_valid` with the FIFO non-empty: pop the head h. Next cycle, `rsp_valid = 1<<h` and `rsp_data` = the captured data.
- On `mem_rsp_valid` with the FIFO empty: set `err_rsp`, leave `rsp_valid` at 0. Only reset clears `err_rsp`.

**FIFO occupancy**
- "Full" means count == OUTSTANDING and is evaluated on registered count only.
- A pop in the same cycle does not unblock a push. There is no combinational path from `mem_rsp_valid` to `req_ready`.
- A push and a pop in the same cycle with the FIFO not full leaves the count unchanged.

## Timing
- Reset values:
  - state IDLE, `prio_ptr`=0, `grant_encoded`=0, `beat_cnt`=0.
  - FIFO empty.
  - `req_ready`=0, `mem_valid`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `err_rsp`=0.
- Reset asserted mid-burst or with reads outstanding: all state clears immediately (asynchronously) and outstanding IDs are discarded. Responses arriving after release set `err_rsp`.
- Grant latency: `req_valid` seen in IDLE at cycle 0 → BURST at cycle 1; the first beat can transfer at cycle 1.
- Last beat at cycle k → IDLE at k+1 (arbitration) → next burst's first beat at k+2. There is one bubble cycle between bursts.
- Response latency: `mem_rsp_valid` at cycle t → `rsp_valid`/`rsp_data` at t+1.
- Peak throughput: 1 beat/cycle inside a burst.

## Structure
- `mem_port_sched_pkg`: state enum (`ST_IDLE`, `ST_BURST`) and a helper function for round-robin next-index.
- Sub-module `mem_port_sched_id_fifo`: a sync FIFO with async active-low reset, width $clog2(PORTS), depth OUTSTANDING, with count, full and empty outputs.
- Arbitration, beat counter and muxing are in the top module.

## Test plan
- **Single read burst:** port 0 read burst, `len`=3, `addr`=0x100, `mem_ready`=1 → grant at cycle 1; beats at cycles 1–4; mem_addr follows the requester. Four responses return as `rsp_valid`=4'b0001.
- **Round-robin order:** all 4 ports hold single-beat writes → grant order 0,1,2,3,0 with one IDLE cycle between bursts; `rsp_valid` stays 0.
- **FIFO full:** `OUTSTANDING`=4, responses withheld, port 1 read `len`=7 → exactly 4 beats accepted, then `req_ready[1]`=0. After the first response, the 5th beat is accepted the following cycle.
- **Stall mid-burst:** `mem_ready`=0 for 3 cycles mid-burst → no transfer, `beat_cnt` held, grant held. The burst resumes and completes with `len+1` beats total.
- **Unexpected response:** `mem_rsp_valid` with the FIFO empty → `err_rsp`=1 from the next cycle until reset; `rsp_valid` stays 0.
- **Reset mid-burst:** `rst_n` low during beat 2 of port 2 → outputs at reset values with no clock edge needed. After release, simultaneous requests from ports 2 and 3 are granted to port 2 (`prio_ptr`=0).
